// File: rtl/alu_operand_regs_if.sv
// Bundles the operand/flags register block's bus, strobes, ALU status and outputs.
interface alu_operand_regs_if;
  logic [7:0] bus;
  logic       load_l_n;
  logic       load_r_n;
  logic       flags_load_n;
  logic       alu_cout;
  logic       alu_vout;
  logic [1:0] carry_sel;
  logic [7:0] arg_l;
  logic [7:0] arg_r;
  logic       cin;
  logic [3:0] flags;

  // Controller / stimulus side: drives strobes and bus, observes registers.
  modport master (
    output bus, load_l_n, load_r_n, flags_load_n, alu_cout, alu_vout, carry_sel,
    input  arg_l, arg_r, cin, flags
  );

  // Register block side.
  modport slave (
    input  bus, load_l_n, load_r_n, flags_load_n, alu_cout, alu_vout, carry_sel,
    output arg_l, arg_r, cin, flags
  );
endinterface

// File: rtl/alu_operand_regs.sv
// ALU operand latches (left/right) and {N,Z,V,C} status register with
// carry-in selection for the add/sub unit.
module alu_operand_regs #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input logic              clk,
  input logic              rst,
  alu_operand_regs_if.slave io
);

  logic [7:0] arg_l_q;
  logic [7:0] arg_r_q;
  logic [3:0] flags_q;
  logic       cin_c;

  // Operand and flags capture from the bus; reset wins over every strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      arg_l_q <= '0;
      arg_r_q <= '0;
      flags_q <= FLAGS_RST;
    end else begin
      if (!io.load_l_n) arg_l_q <= io.bus;
      if (!io.load_r_n) arg_r_q <= io.bus;
      if (!io.flags_load_n)
        flags_q <= {io.bus[7], (io.bus == 8'h00), io.alu_vout, io.alu_cout};
    end
  end

  // Carry-in source select from the stored (pre-update) C bit.
  always_comb begin
    cin_c = 1'b0;
    case (io.carry_sel)
      2'b00:   cin_c = 1'b0;
      2'b01:   cin_c = 1'b1;
      2'b10:   cin_c = flags_q[0];
      2'b11:   cin_c = ~flags_q[0];
      default: cin_c = 1'b0;
    endcase
  end

  assign io.arg_l = arg_l_q;
  assign io.arg_r = arg_r_q;
  assign io.flags = flags_q;
  assign io.cin   = cin_c;

endmodule

// File: tb/tb_alu_operand_regs.sv
// Bench for alu_operand_regs: directed vectors, a cycle model, literal checks.
module tb_alu_operand_regs;
  localparam logic [3:0] FR = 4'b0000;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   check_en = 1'b0;

  alu_operand_regs_if io ();

  alu_operand_regs #(.FLAGS_RST(FR)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  // Reference state: what each register must hold after the last edge.
  logic [7:0] m_l, m_r;
  logic       m_n, m_z, m_v, m_c;

  always @(posedge clk) begin
    if (rst) begin
      m_l <= 8'h00; m_r <= 8'h00;
      {m_n, m_z, m_v, m_c} <= FR;
    end else begin
      if (io.load_l_n == 1'b0) m_l <= io.bus;
      if (io.load_r_n == 1'b0) m_r <= io.bus;
      if (io.flags_load_n == 1'b0) begin
        m_n <= io.bus[7];
        m_z <= (io.bus == 8'd0);
        m_v <= io.alu_vout;
        m_c <= io.alu_cout;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_arg_l", io.arg_l, m_l);
      chk("model_arg_r", io.arg_r, m_r);
      chk("model_flags", {4'h0, io.flags}, {4'h0, m_n, m_z, m_v, m_c});
      // 00->0, 01->1, 10->C, 11->~C
      chk("model_cin", {7'h0, io.cin}, {7'h0, (io.carry_sel[1] & m_c) ^ io.carry_sel[0]});
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    io.load_l_n = 1'b1; io.load_r_n = 1'b1; io.flags_load_n = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    io.bus = 8'h00; io.alu_cout = 1'b0; io.alu_vout = 1'b0; io.carry_sel = 2'b00;
    idle();
    cyc(); cyc();
    rst = 1'b0;
    check_en = 1'b1;
    chk("rst_arg_l", io.arg_l, 8'h00);
    chk("rst_arg_r", io.arg_r, 8'h00);
    chk("rst_flags", {4'h0, io.flags}, 8'h00);
    io.carry_sel = 2'b10; #1 chk("rst_cin_10", {7'h0, io.cin}, 8'h00);
    io.carry_sel = 2'b11; #1 chk("rst_cin_11", {7'h0, io.cin}, 8'h01);
    io.carry_sel = 2'b00;

    // Operand loads and hold
    io.bus = 8'h3C; io.load_l_n = 1'b0; cyc(); idle();
    io.bus = 8'hA5; io.load_r_n = 1'b0; cyc(); idle();
    io.bus = 8'h11;
    repeat (10) cyc();
    chk("hold_arg_l", io.arg_l, 8'h3C);
    chk("hold_arg_r", io.arg_r, 8'hA5);

    // Dual load
    io.bus = 8'h7E; io.load_l_n = 1'b0; io.load_r_n = 1'b0; cyc(); idle();
    chk("dual_arg_l", io.arg_l, 8'h7E);
    chk("dual_arg_r", io.arg_r, 8'h7E);

    // Flags: zero with carry, then negative with overflow
    io.bus = 8'h00; io.alu_cout = 1'b1; io.alu_vout = 1'b0; io.flags_load_n = 1'b0; cyc(); idle();
    chk("flags_zc", {4'h0, io.flags}, 8'h05);
    chk("flags_zc_hold_l", io.arg_l, 8'h7E);
    io.bus = 8'h80; io.alu_cout = 1'b0; io.alu_vout = 1'b1; io.flags_load_n = 1'b0; cyc(); idle();
    chk("flags_nv", {4'h0, io.flags}, 8'h0A);

    // Carry chain
    io.bus = 8'h01; io.alu_cout = 1'b1; io.alu_vout = 1'b0; io.flags_load_n = 1'b0; cyc(); idle();
    chk("flags_c", {4'h0, io.flags}, 8'h01);
    io.carry_sel = 2'b10; io.alu_cout = 1'b0; io.flags_load_n = 1'b0;
    #1 chk("chain_cin_pre", {7'h0, io.cin}, 8'h01);
    cyc(); idle();
    chk("chain_cin_post", {7'h0, io.cin}, 8'h00);
    io.carry_sel = 2'b11; #1 chk("chain_cin_11", {7'h0, io.cin}, 8'h01);
    io.carry_sel = 2'b00; #1 chk("chain_cin_00", {7'h0, io.cin}, 8'h00);
    io.carry_sel = 2'b01; #1 chk("chain_cin_01", {7'h0, io.cin}, 8'h01);

    // Simultaneous operand and flags load
    io.bus = 8'hC3; io.alu_cout = 1'b1; io.alu_vout = 1'b1;
    io.load_l_n = 1'b0; io.load_r_n = 1'b0; io.flags_load_n = 1'b0; cyc(); idle();
    chk("sim_arg_l", io.arg_l, 8'hC3);
    chk("sim_arg_r", io.arg_r, 8'hC3);
    chk("sim_flags", {4'h0, io.flags}, 8'h0B);

    // Reset priority, then resume
    rst = 1'b1; io.bus = 8'hFF; io.alu_cout = 1'b1; io.alu_vout = 1'b0;
    io.load_l_n = 1'b0; io.flags_load_n = 1'b0; cyc();
    chk("rstp_arg_l", io.arg_l, 8'h00);
    chk("rstp_arg_r", io.arg_r, 8'h00);
    chk("rstp_flags", {4'h0, io.flags}, {4'h0, FR});
    rst = 1'b0; cyc(); idle();
    chk("resume_arg_l", io.arg_l, 8'hFF);
    chk("resume_flags", {4'h0, io.flags}, 8'h09);

    // Undriven bits are captured as-is
    io.bus = 8'bxxxx_0101; io.load_r_n = 1'b0; cyc(); idle();
    chk("x_arg_r", io.arg_r, 8'bxxxx_0101);
    chk("x_arg_l", io.arg_l, 8'hFF);
    io.bus = 8'h00;
    cyc(); cyc();

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_operand_regs.md
ALU_OPERAND_REGS -- requirements
Module: alu_operand_regs

Interface
REQ-001 Parameter: FLAGS_RST, default 4'b0000; reset value of the flags register {N,Z,V,C}.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 bus  input  8  shared data bus value (reader side of the bus buffers).
REQ-005 load_l_n  input  1  active-low; capture bus into left operand register.
REQ-006 load_r_n  input  1  active-low; capture bus into right operand register.
REQ-007 flags_load_n  input  1  active-low; capture ALU status into flags register.
REQ-008 alu_cout  input  1  carry/not-borrow from the add/sub unit, already corrected for sub.
REQ-009 alu_vout  input  1  signed overflow from the add/sub unit.
REQ-010 carry_sel  input  2  carry-in source: 00 = 0, 01 = 1, 10 = stored C, 11 = inverted stored C.
REQ-011 arg_l  output  8  left operand register contents.
REQ-012 arg_r  output  8  right operand register contents.
REQ-013 cin  output  1  carry-in to the add/sub unit.
REQ-014 flags  output  4  {N,Z,V,C} register contents.

Function
REQ-015 arg_l SHALL take the bus value at the clock edge where load_l_n = 0; otherwise it holds.
REQ-016 arg_r SHALL take the bus value at the clock edge where load_r_n = 0; otherwise it holds.
REQ-017 With load_l_n and load_r_n both low, both registers SHALL load the same bus value in the same cycle.
REQ-018 arg_l and arg_r SHALL be registered outputs with no combinational path from the bus; a load is visible one cycle after the edge.
REQ-019 At the edge where flags_load_n = 0, the register SHALL capture:
- C = alu_cout
- V = alu_vout
- Z = (bus == 8'h00)
- N = bus[7]
The bus carries the ALU result in that cycle.
REQ-020 flags SHALL hold when flags_load_n = 1.
REQ-021 cin SHALL be combinational from carry_sel and the stored C bit; the stored C is the value before any same-cycle flags update.
REQ-022 Simultaneous flags load and operand load SHALL both take effect in one edge; the operand registers receive the bus value, the same value used for Z/N.
REQ-023 A flags load in cycle n SHALL affect cin only from cycle n+1, so chained ADC/SBC uses the previous operation's carry.
REQ-024 Undriven bus bits (X/Z) during a load SHALL be captured as-is; the block does no bus arbitration.

Reset
REQ-025 While rst = 1 at a clock edge:
- arg_l = 8'h00
- arg_r = 8'h00
- flags = FLAGS_RST
REQ-026 rst SHALL override all load strobes in the same cycle.
REQ-027 A load or flags capture in progress when rst asserts SHALL be discarded, with no partial update.
REQ-028 With flags = 4'b0000 after reset, cin SHALL equal 0 for carry_sel = 10 and 1 for carry_sel = 11.

Verification
REQ-029 Operand load: reset; bus=8'h3C with load_l_n=0 for 1 cycle; then bus=8'hA5 with load_r_n=0 -> arg_l=8'h3C, arg_r=8'hA5; both hold for 10 idle cycles.
REQ-030 Dual load: load_l_n=load_r_n=0, bus=8'h7E -> both registers 8'h7E the next cycle.
REQ-031 Flags capture, zero with carry: flags_load_n=0, bus=8'h00, alu_cout=1, alu_vout=0 -> flags=4'b0101.
REQ-032 Flags capture, negative with overflow: bus=8'h80, alu_cout=0, alu_vout=1 -> flags=4'b1010.
REQ-033 Carry chain: set C=1, carry_sel=10 -> cin=1; in the same cycle flags_load with alu_cout=0 -> cin stays 1 until the edge, then 0; carry_sel=11 -> cin=1; carry_sel=00 -> 0; carry_sel=01 -> 1.
REQ-034 Reset priority: rst=1 with load_l_n=0, flags_load_n=0, bus=8'hFF -> arg_l=8'h00, flags=FLAGS_RST; after rst deasserts, loads resume normally on the next edge.
